hill_key_inverter: RTL and testbench
====================================

Name: hill_key_inverter

Overview:
- Computes the mod-26 inverse of a 3x3 Hill cipher key matrix.
- Streams the inverse out over a key-write port. That port has the same shape as the key-load port of hill_cipher_crypto (key_data/key_addr/key_wen), so the decryption key can be loaded directly into the cipher core.
- This is the decrypt-side counterpart of the key path: software loads the encryption key once and obtains the decryption key in hardware.
- Flags singular keys (gcd(det, 26) != 1) and emits nothing for them.

Parameters:
- BLOCK_SIZE, 3, matrix dimension; only 3 is supported.
- DATA_WIDTH, 8, width of key entries in and out.
- MODULUS, 26, alphabet size; all arithmetic is mod MODULUS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins inversion of the stored key.
- key_data  in  DATA_WIDTH  key entry to store.
- key_addr  in  4  entry index, row-major, r*3+c, range 0..8.
- key_wen  in  1  write strobe for key_data/key_addr.
- inv_key_data  out  DATA_WIDTH  inverse-key entry, 0..25.
- inv_key_addr  out  4  row-major index of inv_key_data.
- inv_key_wen  out  1  inverse entry valid this cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- singular  out  1  result flag for the last run; holds until the next start.

Behaviour:
- Reset (async, rst_n low):
  - All key registers are 0 and the FSM is in IDLE.
  - All outputs are 0: inv_key_data, inv_key_addr, inv_key_wen, busy, done, singular.
  - Reset asserted mid-operation aborts immediately; no further writes occur.
- Key storage:
  - When key_wen=1 on a rising edge in IDLE, key[key_addr] <= key_data mod 26.
  - Writes with key_addr > 8 are ignored.
  - key_wen is ignored while busy.
- start:
  - Sampled only in IDLE; ignored while busy.
  - On start, singular is cleared and the FSM enters COF.
- FSM: IDLE -> COF -> DET -> SRCH -> EMIT -> FIN -> IDLE.
- COF (9 cycles, counter k = 0..8, i = k/3, j = k%3):
  - m = (p1 + 26 - p2) mod 26, where p1 and p2 are the two 2x2 minor products, each reduced mod 26.
  - Cofactor C[i][j] = m if (i+j) is even, else (26 - m) mod 26.
  - C[i][j] is registered.
- DET (1 cycle):
  - det = (key[0]*C00 + key[1]*C01 + key[2]*C02) mod 26.
  - If det is even or det == 13: set singular=1 and go to FIN; no EMIT writes are produced.
  - Otherwise go to SRCH.
- SRCH:
  - Candidate counter starts at 1 and tests one candidate per cycle: (det*cand) mod 26 == 1.
  - On a hit, dinv <= cand and the FSM goes to EMIT. A hit occurs after dinv cycles, worst case 25.
  - If cand reaches 25 with no hit, set singular=1 and go to FIN as a safety path.
- EMIT (9 cycles, addr a = 0..8, r = a/3, c = a%3):
  - inv_key_wen=1, inv_key_addr=a, inv_key_data = (dinv * C[c][r]) mod 26, using the transposed cofactor (adjugate).
  - Entries are strictly in order 0..8 with no gaps; inv_key_wen is high for exactly 9 consecutive cycles.
- FIN: done=1 for one cycle, busy drops the same cycle, then IDLE.
- Latency from the start edge to done:
  - Invertible: 9 + 1 + dinv + 9 + 1 cycles.
  - Singular: 9 + 1 + 1 cycles.
- Output hygiene: inv_key_data and inv_key_addr return to 0 whenever inv_key_wen=0.
- Width rules:
  - Products are at most 25*25 = 625, so 10-bit intermediates.
  - The determinant sum is at most 3*625, so 11-bit intermediates.
  - Reduction is by comparison/subtraction or the % operator; no negative intermediates.
- Key registers are unchanged by a run; repeated start re-inverts the same key.

Test Plan:
- Load key GYBNQKURP (6,24,1,13,16,10,20,17,15), pulse start:
  - det = 25, dinv = 25.
  - Writes addr 0..8 = 8,5,10,21,8,21,21,12,8.
  - singular = 0; done 45 cycles after start.
- Load identity (1,0,0,0,1,0,0,0,1), start:
  - Writes 1,0,0,0,1,0,0,0,1; done 21 cycles after start.
- Load diag(2,1,1), start:
  - singular = 1, no inv_key_wen pulses, done 11 cycles after start.
  - Repeat with diag(13,1,1): same result.
- Chain: feed GYBNQKURP's inverse outputs into hill_cipher_crypto key port, decrypt ciphertext POH -> plaintext ACT.
- Assert key_wen (addr 0, data 3) and start mid-SRCH:
  - Both ignored; output identical to the GYBNQKURP case.
  - After done, key[0] is still 6.
- Drop rst_n during EMIT after addr 3:
  - All outputs 0 immediately, no further writes.
  - After release, start reproduces the full 9-entry result from key registers reloaded post-reset.

Source files
------------

// File: rtl/hill_key_inverter.sv
// hill_key_inverter
//   Computes the mod-26 inverse of a 3x3 Hill cipher key and streams it out
//   on a key-write port shaped like the cipher core's key-load port. The
//   decrypt key can therefore be written straight into the cipher.
//
//   Datapath: the nine cofactors are computed one per cycle. The determinant
//   is formed from row 0. The inverse of the determinant is found by a linear
//   search over the candidates. Each output entry is dinv * C[c][r], which is
//   the adjugate scaled by dinv.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   start             one-cycle pulse, accepted only in IDLE
//   key_data/addr/wen key entry load (row-major r*3+c), accepted only in IDLE
//   inv_key_data/addr/wen  inverse entry stream, 9 consecutive cycles
//   busy              high from the cycle after start until done
//   done              one-cycle completion pulse
//   singular          key not invertible mod 26; held until the next start
module hill_key_inverter #(
  parameter int BLOCK_SIZE = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MODULUS    = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] key_data,
  input  logic [3:0]            key_addr,
  input  logic                  key_wen,
  output logic [DATA_WIDTH-1:0] inv_key_data,
  output logic [3:0]            inv_key_addr,
  output logic                  inv_key_wen,
  output logic                  busy,
  output logic                  done,
  output logic                  singular
);

  localparam int          NE   = BLOCK_SIZE * BLOCK_SIZE;
  localparam int          RW   = $clog2(MODULUS);
  // All intermediates are 11 bits wide. The largest value is the
  // determinant sum, 3 * 25 * 25 = 1875.
  localparam logic [10:0] M11  = 11'(MODULUS);
  localparam logic [3:0]  LAST = 4'(NE - 1);

  typedef enum logic [2:0] {IDLE, COF, DET, SRCH, EMIT, FIN} state_t;

  state_t        state;
  logic [RW-1:0] key [NE];
  logic [RW-1:0] cof [NE];
  logic [3:0]    cnt;     // cofactor index in COF, output address in EMIT
  logic [RW-1:0] cand;
  logic [RW-1:0] det_r;
  logic [RW-1:0] dinv;

  function automatic logic [RW-1:0] mulmod(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [10:0] p;
    p = 11'(a) * 11'(b);
    return RW'(p % M11);
  endfunction

  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  // Split cnt into (i, j) = (cnt/3, cnt%3).
  logic [1:0] ci, cj;
  always_comb begin
    ci = 2'd0;
    if (cnt >= 4'd6)      ci = 2'd2;
    else if (cnt >= 4'd3) ci = 2'd1;
    cj = 2'(cnt - 4'(ci) * 4'd3);
  end

  // Cofactor C[ci][cj] is the signed 2x2 minor formed from the rows and
  // columns other than ci and cj. Each term is kept non-negative by adding
  // MODULUS before the subtraction.
  logic [1:0]    r0, r1, c0, c1;
  logic [RW-1:0] p1, p2, minor, cof_val;
  logic [10:0]   msum;
  always_comb begin
    r0      = (ci == 2'd0) ? 2'd1 : 2'd0;
    r1      = (ci == 2'd2) ? 2'd1 : 2'd2;
    c0      = (cj == 2'd0) ? 2'd1 : 2'd0;
    c1      = (cj == 2'd2) ? 2'd1 : 2'd2;
    p1      = mulmod(key[idx(r0, c0)], key[idx(r1, c1)]);
    p2      = mulmod(key[idx(r0, c1)], key[idx(r1, c0)]);
    msum    = 11'(p1) + M11 - 11'(p2);
    minor   = RW'(msum % M11);
    cof_val = minor;
    if ((ci[0] ^ cj[0]) && (minor != '0)) cof_val = RW'(M11 - 11'(minor));
  end

  // Determinant by expansion along row 0.
  logic [10:0]   dsum;
  logic [RW-1:0] det_val;
  always_comb begin
    dsum    = 11'(key[0]) * 11'(cof[0]) + 11'(key[1]) * 11'(cof[1])
            + 11'(key[2]) * 11'(cof[2]);
    det_val = RW'(dsum % M11);
  end

  // The output at address (r, c) uses the transposed cofactor C[c][r].
  logic [3:0] adj;
  assign adj = idx(cj, ci);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      for (int n = 0; n < NE; n++) begin
        key[n] <= '0;
        cof[n] <= '0;
      end
      cnt          <= '0;
      cand         <= '0;
      det_r        <= '0;
      dinv         <= '0;
      inv_key_data <= '0;
      inv_key_addr <= '0;
      inv_key_wen  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      singular     <= 1'b0;
    end else begin
      // Output data and address stay at zero whenever inv_key_wen is low.
      inv_key_data <= '0;
      inv_key_addr <= '0;
      inv_key_wen  <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (key_wen && key_addr <= LAST)
            key[key_addr] <= RW'(11'(key_data) % M11);
          if (start) begin
            singular <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= COF;
          end
        end
        COF: begin
          cof[cnt] <= cof_val;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DET;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DET: begin
          det_r <= det_val;
          // A residue is a unit mod 26 exactly when it is odd and not 13.
          if (!det_val[0] || det_val == RW'(MODULUS / 2)) begin
            singular <= 1'b1;
            state    <= FIN;
          end else begin
            cand  <= RW'(1);
            state <= SRCH;
          end
        end
        SRCH: begin
          if (mulmod(det_r, cand) == RW'(1)) begin
            dinv  <= cand;
            cnt   <= '0;
            state <= EMIT;
          end else if (cand == RW'(MODULUS - 1)) begin
            // Unreachable when DET has already filtered non-units. This
            // branch keeps the FSM from hanging in SRCH.
            singular <= 1'b1;
            state    <= FIN;
          end else begin
            cand <= cand + RW'(1);
          end
        end
        EMIT: begin
          inv_key_wen  <= 1'b1;
          inv_key_addr <= cnt;
          inv_key_data <= DATA_WIDTH'(mulmod(dinv, cof[adj]));
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hill_key_inverter.sv
module tb_hill_key_inverter;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_wen = 1'b0;
  logic [7:0] key_data = '0;
  logic [3:0] key_addr = '0;
  logic [7:0] inv_key_data;
  logic [3:0] inv_key_addr;
  logic       inv_key_wen, busy, done, singular;

  hill_key_inverter dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key_data(key_data), .key_addr(key_addr), .key_wen(key_wen),
    .inv_key_data(inv_key_data), .inv_key_addr(inv_key_addr),
    .inv_key_wen(inv_key_wen), .busy(busy), .done(done), .singular(singular)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0, wr_n = 0, hyg = 0;
  int wr_d [16];
  int wr_a [16];
  int wr_c [16];

  int k_gyb [9] = '{6, 24, 1, 13, 16, 10, 20, 17, 15};
  int e_gyb [9] = '{8, 5, 10, 21, 8, 21, 21, 12, 8};
  int k_id  [9] = '{27, 0, 0, 0, 1, 0, 0, 0, 53};  // reduces to identity
  int e_id  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int k_d2  [9] = '{2, 0, 0, 0, 1, 0, 0, 0, 1};
  int k_d13 [9] = '{13, 0, 0, 0, 1, 0, 0, 0, 1};

  // Write capture, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (inv_key_wen) begin
      if (wr_n < 16) begin
        wr_d[wr_n] = int'(inv_key_data);
        wr_a[wr_n] = int'(inv_key_addr);
        wr_c[wr_n] = cyc;
      end
      wr_n++;
    end else if (inv_key_data != '0 || inv_key_addr != '0) begin
      hyg++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_key(input int v [9]);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      key_wen = 1'b1; key_addr = 4'(i); key_data = 8'(v[i]);
    end
    @(posedge clk); #1;
    // An out-of-range address must not alias onto any key entry.
    key_wen = 1'b1; key_addr = 4'd9; key_data = 8'd5;
    @(posedge clk); #1;
    key_wen = 1'b0; key_addr = '0; key_data = '0;
  endtask

  // Pulses start and returns the cycle count from the start edge to done.
  // With inj set, a key write and a second start are driven during SRCH.
  task automatic run(input bit inj, output int lat);
    wr_n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    lat = 0;
    while (!done && lat < 100) begin
      if (inj && lat == 15) begin
        key_wen = 1'b1; key_addr = 4'd0; key_data = 8'd3; start = 1'b1;
      end else begin
        key_wen = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    key_wen = 1'b0; start = 1'b0;
    chk("busy_at_done", int'(busy), 0);
  endtask

  task automatic chk_writes(input string tag, input int e [9]);
    chk({tag, "_nwr"}, wr_n, 9);
    for (int i = 0; i < 9 && i < wr_n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_a[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_d[i], e[i]);
      chk($sformatf("%s_gap%0d", tag, i), wr_c[i] - wr_c[0], i);
    end
  endtask

  initial begin
    int lat, t, p;
    int ct [3] = '{15, 14, 7};   // POH
    int pt [3] = '{0, 2, 19};    // ACT

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({inv_key_data, inv_key_addr, inv_key_wen, busy, done, singular}), 0);
    rst_n = 1'b1;

    // GYBNQKURP
    load_key(k_gyb);
    run(1'b0, lat);
    chk("gyb_latency", lat, 45);
    chk("gyb_singular", int'(singular), 0);
    chk_writes("gyb", e_gyb);
    // Decrypt POH with the inverse key: P = Kinv * C mod 26.
    for (int r = 0; r < 3; r++) begin
      p = 0;
      for (int c = 0; c < 3; c++) p += wr_d[r * 3 + c] * ct[c];
      chk($sformatf("decrypt%0d", r), p % 26, pt[r]);
    end

    // Identity, with entries above 26 that reduce to 1.
    load_key(k_id);
    run(1'b0, lat);
    chk("id_latency", lat, 21);
    chk_writes("id", e_id);

    // Singular keys
    load_key(k_d2);
    run(1'b0, lat);
    chk("d2_latency", lat, 11);
    chk("d2_singular", int'(singular), 1);
    chk("d2_nwr", wr_n, 0);
    repeat (3) @(posedge clk);
    #1 chk("d2_singular_hold", int'(singular), 1);
    load_key(k_d13);
    run(1'b0, lat);
    chk("d13_latency", lat, 11);
    chk("d13_singular", int'(singular), 1);
    chk("d13_nwr", wr_n, 0);

    // Key write and start driven mid-SRCH must both be ignored.
    load_key(k_gyb);
    run(1'b0, lat);
    chk("pre_inj_singular", int'(singular), 0);
    run(1'b1, lat);
    chk("inj_latency", lat, 45);
    chk_writes("inj", e_gyb);
    // A repeat run still produces the GYB inverse, so key[0] is still 6.
    run(1'b0, lat);
    chk("rerun_latency", lat, 45);
    chk_writes("rerun", e_gyb);

    // Reset during EMIT after addr 3 has been written.
    wr_n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (wr_n < 4 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk("rst_reach_addr3", wr_n, 4);
    rst_n = 1'b0;
    #1 chk("rst_outputs", int'({inv_key_data, inv_key_addr, inv_key_wen, busy, done, singular}), 0);
    repeat (4) @(posedge clk);
    #1 chk("rst_no_more_writes", wr_n, 4);
    rst_n = 1'b1;
    // The key registers were cleared by reset, so the all-zero key is singular.
    run(1'b0, lat);
    chk("rst_zero_key_singular", int'(singular), 1);
    chk("rst_zero_key_latency", lat, 11);
    load_key(k_gyb);
    run(1'b0, lat);
    chk("post_rst_latency", lat, 45);
    chk_writes("post_rst", e_gyb);

    chk("hygiene", hyg, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
